// File: rtl/clock_pkg.sv
// Shared types and limits for the 24-hour BCD timekeeping core.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    // Displayed time, most significant digit first (matches digit1..digit4).
    typedef struct packed {
        bcd_t hour_tens;
        bcd_t hour_units;
        bcd_t min_tens;
        bcd_t min_units;
    } hhmm_t;

    // Raw asynchronous controls, bundled so one synchroniser chain carries all three.
    typedef struct packed {
        logic set_en;
        logic btn_hour;
        logic btn_min;
    } ctl_t;

    localparam int MAX_SEC  = 59;
    localparam int MAX_MIN  = 59;
    localparam int MAX_HOUR = 23;

    localparam hhmm_t RESET_TIME = '{hour_tens: 4'd0, hour_units: 4'd0,
                                     min_tens: 4'd0, min_units: 4'd0};

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-(MAX+1) counter; carry_o is combinational so chained
// instances all roll over on the same edge.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int   MAX       = 59,
    parameter bcd_t RST_TENS  = 4'd0,
    parameter bcd_t RST_UNITS = 4'd0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output bcd_t tens_o,
    output bcd_t units_o,
    output logic carry_o
);

    localparam bcd_t MAX_TENS  = bcd_t'(MAX / 10);
    localparam bcd_t MAX_UNITS = bcd_t'(MAX % 10);

    bcd_t tens_q, tens_d;
    bcd_t units_q, units_d;
    logic at_max;

    assign at_max  = (tens_q == MAX_TENS) && (units_q == MAX_UNITS);
    assign carry_o = inc_i && !clr_i && at_max;

    always_comb begin
        // NOTE: every next-state signal takes a default first so no path infers a latch.
        tens_d  = tens_q;
        units_d = units_q;
        if (clr_i) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (inc_i) begin
            if (at_max) begin
                tens_d  = 4'd0;
                units_d = 4'd0;
            end else if (units_q == 4'd9) begin
                tens_d  = tens_q + 4'd1;
                units_d = 4'd0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q  <= RST_TENS;
            units_q <= RST_UNITS;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens_o  = tens_q;
    assign units_o = units_q;

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS timekeeper with 1 Hz prescaler, blinking colon and
// synchronised set-mode buttons for hour/minute adjustment.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  logic       btn_hour,
    input  logic       btn_min,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic       ptflag,
    output logic       tick_1hz
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]              presc_q, presc_d;
    ctl_t [SYNC_STAGES-1:0]     sync_q;
    ctl_t                       synced;
    logic                       hour_hist_q, min_hist_q;
    logic                       tick_q, ptflag_q;
    logic                       run, wrap, press_hour, press_min;
    logic                       sec_carry, min_carry, hour_carry_unused;
    logic [7:0]                 sec_bcd_unused;

    assign synced     = sync_q[SYNC_STAGES-1];
    assign run        = !synced.set_en;
    assign wrap       = run && (presc_q == PW'(TICK_DIV - 1));
    assign press_hour = synced.btn_hour && !hour_hist_q;
    assign press_min  = synced.btn_min  && !min_hist_q;

    // Set mode parks the prescaler at 0, so leaving it always restarts a full second.
    assign presc_d = (!run || wrap) ? '0 : presc_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            sync_q      <= '0;
            hour_hist_q <= 1'b0;
            min_hist_q  <= 1'b0;
            tick_q      <= 1'b0;
            ptflag_q    <= 1'b1;
        end else begin
            presc_q     <= presc_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], ctl_t'{set_en, btn_hour, btn_min}};
            // History tracks in both modes, so run-mode presses are simply dropped.
            hour_hist_q <= synced.btn_hour;
            min_hist_q  <= synced.btn_min;
            tick_q      <= wrap;
            ptflag_q    <= (presc_d < PW'(TICK_DIV / 2));
        end
    end

    bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (wrap),
        .clr_i   (!run),
        .tens_o  (sec_bcd_unused[7:4]),
        .units_o (sec_bcd_unused[3:0]),
        .carry_o (sec_carry)
    );

    // In set mode the minute wrap must not ripple into hours.
    bcd_mod_counter #(
        .MAX       (MAX_MIN),
        .RST_TENS  (RESET_TIME.min_tens),
        .RST_UNITS (RESET_TIME.min_units)
    ) u_min (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (run ? sec_carry : press_min),
        .clr_i   (1'b0),
        .tens_o  (digit3),
        .units_o (digit4),
        .carry_o (min_carry)
    );

    bcd_mod_counter #(
        .MAX       (MAX_HOUR),
        .RST_TENS  (RESET_TIME.hour_tens),
        .RST_UNITS (RESET_TIME.hour_units)
    ) u_hour (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (run ? min_carry : press_hour),
        .clr_i   (1'b0),
        .tens_o  (digit1),
        .units_o (digit2),
        .carry_o (hour_carry_unused)
    );

    assign tick_1hz = tick_q;
    assign ptflag   = ptflag_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter with a seconds-of-day reference model
// checked against the DUT on every falling clock edge.
module tb_bcd_time_counter;

    localparam int TICK_DIV = 4;
    localparam int SYNC     = 2;

    logic       clk = 1'b0;
    logic       rst_n, set_en, btn_hour, btn_min;
    logic [3:0] digit1, digit2, digit3, digit4;
    logic       ptflag, tick_1hz;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_time_counter #(.TICK_DIV(TICK_DIV), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en),
        .btn_hour (btn_hour),
        .btn_min  (btn_min),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .digit4   (digit4),
        .ptflag   (ptflag),
        .tick_1hz (tick_1hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time of day as plain seconds, a cycle phase within the
    // current second, and the raw inputs delayed by the synchroniser depth.
    int        tod, phase, m_h, m_m;
    bit        m_tick, hr_press, mn_press, hr_prev, mn_prev;
    bit [SYNC-1:0] set_s, hr_s, mn_s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tod = 0; phase = 0; m_tick = 0;
            set_s = '0; hr_s = '0; mn_s = '0;
            hr_prev = 0; mn_prev = 0;
        end else begin
            hr_press = hr_s[SYNC-1] && !hr_prev;
            mn_press = mn_s[SYNC-1] && !mn_prev;
            if (set_s[SYNC-1]) begin
                phase  = 0;
                m_tick = 0;
                m_h = tod / 3600;
                m_m = (tod / 60) % 60;
                if (hr_press) m_h = (m_h + 1) % 24;
                if (mn_press) m_m = (m_m + 1) % 60;
                tod = m_h * 3600 + m_m * 60;
            end else begin
                phase  = (phase + 1) % TICK_DIV;
                m_tick = (phase == 0);
                if (m_tick) tod = (tod + 1) % 86400;
            end
            hr_prev = hr_s[SYNC-1];
            mn_prev = mn_s[SYNC-1];
            set_s = {set_s[SYNC-2:0], set_en};
            hr_s  = {hr_s[SYNC-2:0], btn_hour};
            mn_s  = {mn_s[SYNC-2:0], btn_min};
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_digit1", digit1, (tod / 3600) / 10);
            check("model_digit2", digit2, (tod / 3600) % 10);
            check("model_digit3", digit3, ((tod / 60) % 60) / 10);
            check("model_digit4", digit4, ((tod / 60) % 60) % 10);
            check("model_ptflag", ptflag, int'(phase < TICK_DIV / 2));
            check("model_tick",   tick_1hz, int'(m_tick));
        end
    end

    int tick_cnt = 0;
    bit in_set   = 0;
    int set_viol = 0;
    always @(negedge clk) begin
        if (rst_n && tick_1hz) tick_cnt++;
        if (in_set && (!ptflag || tick_1hz)) set_viol++;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input bit hr, input bit mn);
        btn_hour = hr;
        btn_min  = mn;
        repeat (4) cyc();
        btn_hour = 0;
        btn_min  = 0;
        repeat (4) cyc();
    endtask

    task automatic wait_ticks(input int n);
        int target = tick_cnt + n;
        int budget = n * TICK_DIV * 2 + 20;
        while (tick_cnt < target && budget > 0) begin
            cyc();
            budget--;
        end
        check("tick_wait_in_budget", int'(tick_cnt >= target), 1);
    endtask

    function automatic int shown_hour();
        return digit1 * 10 + digit2;
    endfunction

    function automatic int shown_min();
        return digit3 * 10 + digit4;
    endfunction

    bit pat [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int n, base;

    initial begin
        rst_n = 1; set_en = 0; btn_hour = 0; btn_min = 0;
        #1 rst_n = 0;
        cmp_en = 1;
        repeat (3) cyc();
        rst_n = 1;

        // First tick after reset release, then the colon blink pattern.
        n = 0;
        do begin cyc(); n++; end while (!tick_1hz && n < 20);
        check("first_tick_after_reset", n, TICK_DIV);
        for (int j = 0; j < 8; j++) begin
            check("ptflag_pattern", ptflag, pat[j % 4]);
            check("tick_pattern", tick_1hz, int'(j % 4 == 0));
            cyc();
        end

        // Asynchronous reset mid-count, observed between clock edges.
        cyc(); cyc();
        check("ptflag_low_before_reset", ptflag, 0);
        #2 rst_n = 0;
        #1;
        check("async_rst_digits", {digit1, digit2, digit3, digit4}, 0);
        check("async_rst_ptflag", ptflag, 1);
        check("async_rst_tick", tick_1hz, 0);
        repeat (2) cyc();
        rst_n = 1;

        // Run mode: minute and hour carries.
        wait_ticks(59);
        check("hhmm_after_59", shown_hour() * 100 + shown_min(), 0);
        wait_ticks(1);
        check("hhmm_after_60", shown_hour() * 100 + shown_min(), 1);
        wait_ticks(3540);
        check("hhmm_after_3600", shown_hour() * 100 + shown_min(), 100);

        // Set mode: a held button gives one increment, three edges after sampling.
        set_en = 1;
        repeat (SYNC + 2) cyc();
        in_set = 1;
        btn_min = 1;
        cyc(); check("btn_lat_e1", digit4, 0);
        cyc(); check("btn_lat_e2", digit4, 0);
        cyc(); check("btn_lat_e3", digit4, 1);
        repeat (7) cyc();
        check("btn_held_once", shown_hour() * 100 + shown_min(), 101);
        btn_min = 0;
        repeat (4) cyc();

        repeat (23) press(1, 0);
        check("hour_wrap_set", shown_hour() * 100 + shown_min(), 1);
        repeat (58) press(0, 1);
        check("min_to_59", shown_hour() * 100 + shown_min(), 59);
        for (int k = 1; k <= 60; k++) begin
            press(0, 1);
            check("min_cycle", shown_min(), (59 + k) % 60);
            check("min_no_carry", shown_hour(), 0);
        end
        repeat (23) press(1, 0);
        check("set_23_59", shown_hour() * 100 + shown_min(), 2359);
        press(1, 1);
        check("both_press_wrap", {digit1, digit2, digit3, digit4}, 0);
        repeat (23) press(1, 0);
        repeat (59) press(0, 1);
        check("reset_23_59", shown_hour() * 100 + shown_min(), 2359);
        check("set_mode_idle", set_viol, 0);

        // Leave set mode, ignore run presses, then the full rollover.
        in_set = 0;
        set_en = 0;
        n = 0;
        do begin cyc(); n++; end while (!tick_1hz && n < 20);
        check("first_tick_after_set", n, SYNC + TICK_DIV);
        base = tick_cnt;
        press(1, 1);
        check("run_press_ignored", shown_hour() * 100 + shown_min(), 2359);
        wait_ticks(base + 58 - tick_cnt);
        check("pre_rollover", shown_hour() * 100 + shown_min(), 2359);
        wait_ticks(1);
        check("rollover_digits", {digit1, digit2, digit3, digit4}, 0);
        check("rollover_tick", tick_1hz, 1);
        repeat (8) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
